// File: rtl/sync_debounce.sv
// Debounce filter for a single already-synchronized level: accepts a new level
// only after STABLE_CYCLES consecutive differing samples, with edge/glitch strobes.
module sync_debounce #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             data_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             glitch_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam int unsigned MIS_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [MIS_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    logic             mismatch;
    logic             commit;
    logic [CNT_W-1:0] cnt_base;

    assign mismatch = (data_i != level_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mis_cnt_d = mis_cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        glitch_d  = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            ST_STABLE: begin
                if (mismatch) begin
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        mis_cnt_d = MIS_W'(1);
                        state_d   = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (!mismatch) begin
                    // Candidate abandoned: a single matching sample restarts the count.
                    mis_cnt_d = '0;
                    state_d   = ST_STABLE;
                    glitch_d  = 1'b1;
                end else if (mis_cnt_q == MIS_LAST) begin
                    commit = 1'b1;
                end else begin
                    mis_cnt_d = mis_cnt_q + MIS_W'(1);
                end
            end
            default: begin
                state_d   = ST_STABLE;
                mis_cnt_d = '0;
            end
        endcase

        if (commit) begin
            level_d   = ~level_q;
            mis_cnt_d = '0;
            state_d   = ST_STABLE;
            rise_d    = ~level_q;
            fall_d    = level_q;
        end
    end

    // Clear applies first, then a coincident commit is counted on top of it.
    always_comb begin
        cnt_base   = clr_i ? '0 : edge_cnt_q;
        edge_cnt_d = cnt_base;
        if (commit && (cnt_base != CNT_MAX)) begin
            edge_cnt_d = cnt_base + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_STABLE;
            mis_cnt_q  <= '0;
            level_q    <= RESET_VAL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            glitch_q   <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mis_cnt_q  <= mis_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            glitch_q   <= glitch_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign glitch_o   = glitch_q;
    assign edge_cnt_o = edge_cnt_q;

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Consumes the single-bit, already-synchronized level from ff_syncer in the same clock domain.
- Filters out short glitches and produces a debounced level, one-cycle rise/fall strobes, a glitch strobe and a saturating accepted-edge counter.
- Used on slow external inputs (buttons, link-detect, straps) after the synchronizer chain.

Parameters:
- STABLE_CYCLES, 16, consecutive mismatching samples required to accept a new level; legal values >= 1.
- CNT_W, 8, width of the accepted-edge counter.
- RESET_VAL, 1'b0, level_o value after reset; same meaning as the synchronizer's reset value.

Ports:
- clk_i  input  1  clock, shared with the feeding synchronizer.
- rst_ni  input  1  reset; synchronous, active-low.
- data_i  input  1  synchronized level from ff_syncer data_o.
- clr_i  input  1  synchronous clear of edge_cnt_o.
- level_o  output  1  debounced level.
- rise_o  output  1  one-cycle strobe on an accepted 0->1 transition.
- fall_o  output  1  one-cycle strobe on an accepted 1->0 transition.
- glitch_o  output  1  one-cycle strobe when a pending transition is abandoned.
- edge_cnt_o  output  CNT_W  saturating count of accepted transitions.

Behaviour:
Reset
- Reset acts only at a clk_i rising edge where rst_ni=0.
- At that edge: level_o=RESET_VAL; rise_o, fall_o and glitch_o are 0; edge_cnt_o=0; internal count=0; state=STABLE.
- Reset during PENDING abandons the candidate. glitch_o is not asserted for it.

Internal state
- Mismatch counter, width $clog2(STABLE_CYCLES+1).
- States: STABLE (count==0) and PENDING (count!=0).

Per clock edge (rst_ni=1), m = (data_i != level_o)
- STABLE, m=0: hold.
- STABLE, m=1:
  - If STABLE_CYCLES==1: commit.
  - Otherwise: count<=1 and go to PENDING.
- PENDING, m=0: count<=0, go to STABLE, glitch_o=1 for the next cycle.
- PENDING, m=1, count==STABLE_CYCLES-1: commit.
- PENDING, m=1, otherwise: count<=count+1.

Commit
- level_o<=~level_o and count<=0; state returns to STABLE.
- rise_o<=1 if the new level is 1, otherwise fall_o<=1.
- The strobe is high during exactly the cycle in which level_o first shows the new value.

Latency and strobe rules
- If data_i differs from level_o at S=STABLE_CYCLES consecutive sampling edges, level_o changes at the S-th edge.
- Any single matching sample restarts the count from zero.
- All strobes are registered and one cycle wide; rise_o, fall_o and glitch_o are mutually exclusive in any cycle.
- A new candidate can begin on the edge immediately after a commit or an abandon.

Edge counter
- Increments by 1 on each commit and saturates at 2^CNT_W-1.
- clr_i=1 without a commit: edge_cnt_o<=0.
- clr_i=1 in the same edge as a commit: edge_cnt_o<=1 (clear takes effect, then the commit is counted).
- Reset has priority over clr_i and commit.

Test Plan:
1. Reset with defaults, data_i=0 held for 50 cycles -> level_o=0, no strobes, edge_cnt_o=0.
2. data_i 0->1 and held -> level_o=1 and rise_o=1 on the 16th sampling edge with data_i=1, rise_o low on the next cycle, edge_cnt_o=1. Then 1->0 held 16 edges -> fall_o single pulse, edge_cnt_o=2.
3. data_i high for 15 edges then low -> level_o stays 0, glitch_o=1 for exactly one cycle, edge_cnt_o unchanged. A 1-cycle pulse -> glitch_o once.
4. CNT_W=8, STABLE_CYCLES=1, toggle data_i every 2 cycles for 600 cycles -> edge_cnt_o reaches 255 and holds. clr_i alone -> 0. clr_i coincident with a commit -> 1.
5. RESET_VAL=1, rst_ni=0 then data_i=1 -> level_o=1, no strobes. Drive rst_ni=0 at pending count 10 -> next edge shows all outputs reset, glitch_o=0.
6. rst_ni pulsed low between clock edges only -> no state change (synchronous reset check).
